// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx: queues bytes written through the GPIO port into a small FIFO
// and transmits them as 8N1 UART frames, LSB first. The line idles high.
module gpio_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   output logic                          tx,
   output logic                          busy,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [BW-1:0]    baud_cnt;
   logic [BW-1:0]    baud_next;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_next;
   logic [7:0]       shift_reg;
   logic [7:0]       shift_next;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    fifo_cnt;
   logic             overrun_q;
   logic             push;
   logic             pop;

   // A pop only happens when the transmitter is idle and has something queued;
   // a write into a full FIFO is still accepted when that pop frees a slot.
   assign pop  = (state == IDLE) && (fifo_cnt != '0);
   assign push = wr_en && ((fifo_cnt != DEPTH_C) || pop);

   // FIFO storage: no reset needed, the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and the sticky dropped-write flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (wr_en && !push) begin
            overrun_q <= 1'b1;
         end
      end
   end

   // Transmitter state register; reset drops any partial frame immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_next;
         bit_idx   <= bit_next;
         shift_reg <= shift_next;
      end
   end

   // Frame sequencing: start bit, eight data bits LSB first, stop bit, each
   // lasting CLKS_PER_BIT cycles; the line level is decoded from the state.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_idx;
      shift_next = shift_reg;
      tx         = 1'b1;
      case (state)
         IDLE: begin
            tx = 1'b1;
            if (pop) begin
               shift_next = mem[rd_ptr];
               baud_next  = '0;
               state_next = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (baud_cnt == BAUD_LAST) begin
               baud_next  = '0;
               bit_next   = '0;
               state_next = DATA;
            end else begin
               baud_next = baud_cnt + BW'(1);
            end
         end
         DATA: begin
            tx = shift_reg[0];
            if (baud_cnt == BAUD_LAST) begin
               baud_next  = '0;
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_idx + 3'd1;
               end
            end else begin
               baud_next = baud_cnt + BW'(1);
            end
         end
         STOP: begin
            tx = 1'b1;
            if (baud_cnt == BAUD_LAST) begin
               baud_next  = '0;
               state_next = IDLE;
            end else begin
               baud_next = baud_cnt + BW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy    = (state != IDLE) || (fifo_cnt != '0);
   assign full    = (fifo_cnt == DEPTH_C);
   assign count   = fifo_cnt;
   assign overrun = overrun_q;

endmodule
